// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Redirect causes are encoded so that a numerically larger value wins arbitration.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT     = 2'd2,
    ST_WAIT_RDR = 2'd3
  } pc_state_e;

  typedef enum logic [1:0] {
    RDR_NONE = 2'd0,
    RDR_BR   = 2'd1,
    RDR_MRET = 2'd2,
    RDR_TRAP = 2'd3
  } rdr_cause_e;

  localparam int unsigned PC_STEP = 4;

  function automatic logic cause_outranks(input rdr_cause_e challenger, input rdr_cause_e holder);
    return (challenger > holder);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of PC register, instruction-fetch handshake, redirect and flush signals.
// Trap/return signals exist only when PC_SEQUENCER_TRAP_EN is defined.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PC_next;
  logic             PC_En;
  logic             imem_req;
  logic             imem_ready;
  logic             stall;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
`ifdef PC_SEQUENCER_TRAP_EN
  logic             trap_req;
  logic [WIDTH-1:0] trap_vector;
  logic             mret;
  logic [WIDTH-1:0] mepc;
`endif
  logic             flush_IF_ID;
  logic             flush_ID_EX;
  logic             busy;

`ifdef PC_SEQUENCER_TRAP_EN
  modport master (
    input  PC, imem_ready, stall, br_taken, br_target,
           trap_req, trap_vector, mret, mepc,
    output PC_next, PC_En, imem_req, flush_IF_ID, flush_ID_EX, busy
  );

  modport slave (
    output PC, imem_ready, stall, br_taken, br_target,
           trap_req, trap_vector, mret, mepc,
    input  PC_next, PC_En, imem_req, flush_IF_ID, flush_ID_EX, busy
  );
`else
  modport master (
    input  PC, imem_ready, stall, br_taken, br_target,
    output PC_next, PC_En, imem_req, flush_IF_ID, flush_ID_EX, busy
  );

  modport slave (
    output PC, imem_ready, stall, br_taken, br_target,
    input  PC_next, PC_En, imem_req, flush_IF_ID, flush_ID_EX, busy
  );
`endif

endinterface

// File: rtl/pc_sequencer_redirect_arbiter.sv
// Fixed-priority select among redirect sources: trap > mret > branch.
// With PC_SEQUENCER_TRAP_EN undefined the branch is the only source.
module redirect_arbiter
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
`ifdef PC_SEQUENCER_TRAP_EN
  input  logic             trap_req,
  input  logic [WIDTH-1:0] trap_vector,
  input  logic             mret,
  input  logic [WIDTH-1:0] mepc,
`endif
  output rdr_cause_e       cause,
  output logic [WIDTH-1:0] target
);

  // Priority encoder producing the winning cause and its target address
  always_comb begin
    cause  = RDR_NONE;
    target = br_target;
`ifdef PC_SEQUENCER_TRAP_EN
    if (trap_req) begin
      cause  = RDR_TRAP;
      target = trap_vector;
    end else if (mret) begin
      cause  = RDR_MRET;
      target = mepc;
    end else if (br_taken) begin
      cause  = RDR_BR;
      target = br_target;
    end else begin
      cause  = RDR_NONE;
      target = br_target;
    end
`else
    if (br_taken) begin
      cause  = RDR_BR;
      target = br_target;
    end else begin
      cause  = RDR_NONE;
      target = br_target;
    end
`endif
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: boot, sequential advance, redirect arbitration and
// buffering of redirects behind an outstanding fetch. Optional PC_SEQUENCER_TRAP_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}}
) (
  input logic           CLK,
  input logic           Reset,
  pc_sequencer_if.master bus
);

  pc_state_e        state_r;
  pc_state_e        state_nxt_s;
  rdr_cause_e       pend_cause_r;
  rdr_cause_e       pend_cause_nxt_s;
  logic [WIDTH-1:0] pend_target_r;
  logic [WIDTH-1:0] pend_target_nxt_s;

  rdr_cause_e       rdr_cause_s;
  logic [WIDTH-1:0] rdr_target_s;
  logic             has_rdr_s;
  logic             outranks_s;
  logic [WIDTH-1:0] pc_inc_s;

  logic [WIDTH-1:0] pc_next_s;
  logic             pc_en_s;
  logic             imem_req_s;
  logic             flush_if_s;
  logic             flush_ex_s;
  logic             busy_s;

  redirect_arbiter #(.WIDTH(WIDTH)) u_arb (
    .br_taken    (bus.br_taken),
    .br_target   (bus.br_target),
`ifdef PC_SEQUENCER_TRAP_EN
    .trap_req    (bus.trap_req),
    .trap_vector (bus.trap_vector),
    .mret        (bus.mret),
    .mepc        (bus.mepc),
`endif
    .cause       (rdr_cause_s),
    .target      (rdr_target_s)
  );

  assign has_rdr_s  = (rdr_cause_s != RDR_NONE);
  assign outranks_s = cause_outranks(rdr_cause_s, pend_cause_r);
  assign pc_inc_s   = bus.PC + WIDTH'(PC_STEP);

  // Next-state, pending-register and output decode for every state
  always_comb begin
    state_nxt_s       = state_r;
    pend_cause_nxt_s  = pend_cause_r;
    pend_target_nxt_s = pend_target_r;
    pc_next_s         = bus.PC;
    pc_en_s           = 1'b1;
    imem_req_s        = 1'b0;
    flush_if_s        = 1'b0;
    flush_ex_s        = 1'b0;
    busy_s            = 1'b0;

    case (state_r)
      ST_BOOT: begin
        pc_next_s   = RESET_VECTOR;
        pc_en_s     = 1'b0;
        state_nxt_s = ST_RUN;
      end

      ST_RUN: begin
        imem_req_s = 1'b1;
        if (has_rdr_s) begin
          // A fetch completing alongside the redirect is on the wrong path
          pc_next_s  = rdr_target_s;
          pc_en_s    = 1'b0;
          flush_if_s = 1'b1;
          flush_ex_s = 1'b1;
        end else if (bus.imem_ready && !bus.stall) begin
          pc_next_s = pc_inc_s;
          pc_en_s   = 1'b0;
        end else if (!bus.imem_ready) begin
          state_nxt_s = ST_WAIT;
        end else begin
          pc_en_s = 1'b1;
        end
      end

      ST_WAIT: begin
        imem_req_s = 1'b1;
        if (has_rdr_s && bus.imem_ready) begin
          pc_next_s   = rdr_target_s;
          pc_en_s     = 1'b0;
          flush_if_s  = 1'b1;
          flush_ex_s  = 1'b1;
          state_nxt_s = ST_RUN;
        end else if (has_rdr_s) begin
          // The address must stay stable until the fetch completes, so park the target
          pend_cause_nxt_s  = rdr_cause_s;
          pend_target_nxt_s = rdr_target_s;
          flush_ex_s        = 1'b1;
          state_nxt_s       = ST_WAIT_RDR;
        end else if (bus.imem_ready) begin
          state_nxt_s = ST_RUN;
          if (!bus.stall) begin
            pc_next_s = pc_inc_s;
            pc_en_s   = 1'b0;
          end else begin
            pc_en_s = 1'b1;
          end
        end else begin
          pc_en_s = 1'b1;
        end
      end

      ST_WAIT_RDR: begin
        imem_req_s = 1'b1;
        busy_s     = 1'b1;
        if (bus.imem_ready) begin
          pc_next_s         = outranks_s ? rdr_target_s : pend_target_r;
          pc_en_s           = 1'b0;
          flush_if_s        = 1'b1;
          flush_ex_s        = outranks_s;
          pend_cause_nxt_s  = RDR_NONE;
          pend_target_nxt_s = {WIDTH{1'b0}};
          state_nxt_s       = ST_RUN;
        end else if (outranks_s) begin
          pend_cause_nxt_s  = rdr_cause_s;
          pend_target_nxt_s = rdr_target_s;
          flush_ex_s        = 1'b1;
        end else begin
          pc_en_s = 1'b1;
        end
      end

      default: begin
        state_nxt_s = ST_BOOT;
      end
    endcase
  end

  // State and pending-redirect registers
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_r       <= ST_BOOT;
      pend_cause_r  <= RDR_NONE;
      pend_target_r <= {WIDTH{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      pend_cause_r  <= pend_cause_nxt_s;
      pend_target_r <= pend_target_nxt_s;
    end
  end

  // Reset forces the quiescent output set combinationally so a request drops at once
  assign bus.PC_next     = pc_next_s;
  assign bus.PC_En       = Reset ? pc_en_s    : 1'b1;
  assign bus.imem_req    = Reset ? imem_req_s : 1'b0;
  assign bus.flush_IF_ID = Reset ? flush_if_s : 1'b0;
  assign bus.flush_ID_EX = Reset ? flush_ex_s : 1'b0;
  assign bus.busy        = Reset ? busy_s     : 1'b0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic,
// all checked against a transaction-level model of the PC sequencing rules.
module tb_pc_sequencer;

  localparam int          W  = 32;
  localparam logic [31:0] RV = 32'h00000100;

  logic CLK = 1'b0;
  logic Reset;

  pc_sequencer_if #(.WIDTH(W)) bus ();

  pc_sequencer #(.WIDTH(W), .RESET_VECTOR(RV)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Environment PC register, loaded when PC_En is low
  logic [31:0] pc_reg;
  always @(posedge CLK or negedge Reset) begin
    if (!Reset) pc_reg <= 32'h0;
    else if (!bus.PC_En) pc_reg <= bus.PC_next;
  end
  assign bus.PC = pc_reg;

  // Stimulus variables (trap/mret stay 0 when the feature is compiled out)
  logic        t_ready, t_stall, t_br, t_trap, t_mret;
  logic [31:0] t_tgt, t_tvec, t_mepc;

  always_comb begin
    bus.imem_ready = t_ready;
    bus.stall      = t_stall;
    bus.br_taken   = t_br;
    bus.br_target  = t_tgt;
`ifdef PC_SEQUENCER_TRAP_EN
    bus.trap_req    = t_trap;
    bus.trap_vector = t_tvec;
    bus.mret        = t_mret;
    bus.mepc        = t_mepc;
`endif
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: boot done, previous fetch blocked, buffered redirect
  logic        m_booted, m_wait, m_pend_v;
  int          m_pend_prio;
  logic [31:0] m_pend_tgt, m_pc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_booted = 1'b0; m_wait = 1'b0; m_pend_v = 1'b0;
    m_pend_prio = 0; m_pend_tgt = 32'h0; m_pc = 32'h0;
  endtask

  task automatic set_in(input logic rdy, input logic stl, input logic br, input logic [31:0] tgt);
    t_ready = rdy; t_stall = stl; t_br = br; t_tgt = tgt;
    t_trap = 1'b0; t_mret = 1'b0; t_tvec = 32'h0; t_mepc = 32'h0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model
  task automatic cycle_check();
    int          prio;
    logic [31:0] tgt, e_next, n_pt;
    logic        e_req, e_en, e_fif, e_fex, e_busy;
    logic        n_booted, n_wait, n_pv;
    int          n_pp;
    @(negedge CLK);
    e_req = 1'b0; e_en = 1'b1; e_fif = 1'b0; e_fex = 1'b0; e_busy = 1'b0; e_next = 32'h0;
    n_booted = m_booted; n_wait = m_wait; n_pv = m_pend_v; n_pp = m_pend_prio; n_pt = m_pend_tgt;
    prio = t_trap ? 3 : (t_mret ? 2 : (t_br ? 1 : 0));
    tgt  = t_trap ? t_tvec : (t_mret ? t_mepc : t_tgt);
    if (!Reset) begin
      n_booted = 1'b0; n_wait = 1'b0; n_pv = 1'b0; n_pp = 0; n_pt = 32'h0;
    end else if (!m_booted) begin
      e_en = 1'b0; e_next = RV; n_booted = 1'b1;
    end else begin
      e_req = 1'b1; e_busy = m_pend_v;
      if (m_pend_v) begin
        if (t_ready) begin
          e_en = 1'b0; e_fif = 1'b1; e_fex = (prio > m_pend_prio);
          e_next = e_fex ? tgt : m_pend_tgt;
          n_pv = 1'b0; n_pp = 0; n_pt = 32'h0; n_wait = 1'b0;
        end else if (prio > m_pend_prio) begin
          e_fex = 1'b1; n_pp = prio; n_pt = tgt;
        end
      end else if (prio > 0) begin
        e_fex = 1'b1;
        if (!m_wait || t_ready) begin
          e_en = 1'b0; e_fif = 1'b1; e_next = tgt; n_wait = 1'b0;
        end else begin
          n_pv = 1'b1; n_pp = prio; n_pt = tgt;
        end
      end else if (t_ready) begin
        n_wait = 1'b0;
        if (!t_stall) begin
          e_en = 1'b0; e_next = m_pc + 32'd4;
        end
      end else begin
        n_wait = 1'b1;
      end
    end
    check_val("pc",          pc_reg, m_pc);
    check_val("imem_req",    32'(bus.imem_req),    32'(e_req));
    check_val("PC_En",       32'(bus.PC_En),       32'(e_en));
    check_val("flush_IF_ID", 32'(bus.flush_IF_ID), 32'(e_fif));
    check_val("flush_ID_EX", 32'(bus.flush_ID_EX), 32'(e_fex));
    check_val("busy",        32'(bus.busy),        32'(e_busy));
    if (!e_en) check_val("PC_next", bus.PC_next, e_next);
    @(posedge CLK);
    if (!Reset) m_pc = 32'h0;
    else if (!e_en) m_pc = e_next;
    m_booted = n_booted; m_wait = n_wait; m_pend_v = n_pv; m_pend_prio = n_pp; m_pend_tgt = n_pt;
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    model_clear();
    #2 Reset = 1'b0;
    repeat (2) cycle_check();
    Reset = 1'b1;

    // Reset release: one boot cycle, then fetching from the reset vector
    cycle_check();
    check_val("boot_pc", pc_reg, 32'h00000100);
    check_val("boot_req", 32'(bus.imem_req), 32'd1);

    // Streaming
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (4) cycle_check();
    check_val("stream_pc", pc_reg, 32'h00000110);

    // Redirect while a fetch waits
    set_in(1'b1, 1'b0, 1'b1, 32'h00000200);
    cycle_check();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    cycle_check();
    set_in(1'b0, 1'b0, 1'b1, 32'h00000400);
    cycle_check();
    check_val("wrdr_busy", 32'(bus.busy), 32'd1);
    check_val("wrdr_hold", pc_reg, 32'h00000200);
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    cycle_check();
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    cycle_check();
    check_val("wrdr_pc", pc_reg, 32'h00000400);

`ifdef PC_SEQUENCER_TRAP_EN
    // Trap beats a simultaneous branch
    set_in(1'b1, 1'b0, 1'b1, 32'h00000400);
    t_trap = 1'b1; t_tvec = 32'h00000080;
    cycle_check();
    check_val("trap_pc", pc_reg, 32'h00000080);
`endif

    // Stall holds, a redirect overrides it
    set_in(1'b1, 1'b0, 1'b1, 32'h00000300);
    cycle_check();
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) cycle_check();
    check_val("stall_pc", pc_reg, 32'h00000300);
    set_in(1'b1, 1'b1, 1'b1, 32'h00000500);
    cycle_check();
    check_val("stall_br_pc", pc_reg, 32'h00000500);

    // Wrap at the top of the address space
    set_in(1'b1, 1'b0, 1'b1, 32'hFFFFFFFC);
    cycle_check();
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    cycle_check();
    check_val("wrap_pc", pc_reg, 32'h00000000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      t_ready = ($urandom_range(0, 9) < 6);
      t_stall = ($urandom_range(0, 3) == 0);
      t_br    = ($urandom_range(0, 4) == 0);
      t_tgt   = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFFFFFC) : $urandom;
      t_trap  = 1'b0; t_mret = 1'b0; t_tvec = 32'h0; t_mepc = 32'h0;
`ifdef PC_SEQUENCER_TRAP_EN
      t_trap = ($urandom_range(0, 9) == 0);
      t_mret = ($urandom_range(0, 9) == 0);
      t_tvec = $urandom;
      t_mepc = $urandom;
`endif
      cycle_check();
    end

    // Asynchronous reset while a redirect is parked
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    cycle_check();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    cycle_check();
    set_in(1'b0, 1'b0, 1'b1, 32'h00000600);
    cycle_check();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    check_val("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 Reset = 1'b0;
    #1;
    check_val("rst_req", 32'(bus.imem_req), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_pc_en", 32'(bus.PC_En), 32'd1);
    model_clear();
    cycle_check();
    Reset = 1'b1;
    cycle_check();
    check_val("reboot_pc", pc_reg, 32'h00000100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
